// File: rtl/dcache_msi_pkg.sv
// rtl/dcache_msi_pkg.sv - shared widths, MSI encodings and enums for the dcache miss path
package dcache_msi_pkg;

    localparam int LINE_W   = 256;
    localparam int WORD_W   = 32;
    localparam int TAG_W    = 17;
    localparam int INDEX_W  = 10;
    localparam int OFFSET_W = 5;
    localparam int BEATS    = LINE_W / WORD_W;
    localparam int BEAT_W   = $clog2(BEATS);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    localparam logic [1:0] MSI_I = 2'b00;
    localparam logic [1:0] MSI_S = 2'b01;
    localparam logic [1:0] MSI_M = 2'b11;

    typedef enum logic [1:0] {
        CMD_NONE   = 2'b00,
        CMD_BUSRD  = 2'b01,
        CMD_BUSRDX = 2'b10,
        CMD_FLUSH  = 2'b11
    } bus_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WB,
        ST_FILL,
        ST_RESP
    } miss_state_e;

endpackage

// File: rtl/line_beat_buffer.sv
// rtl/line_beat_buffer.sv - one cache line of storage with beat-wide write and read ports
module line_beat_buffer
    import dcache_msi_pkg::*;
(
    input  logic              clk,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [LINE_W-1:0] ld_line_i,
    input  logic              we_i,
    input  logic [BEAT_W-1:0] beat_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic [LINE_W-1:0] line_o
);

    logic [LINE_W-1:0] line_q;

    // Whole-line load captures the victim; beat writes then overwrite it with refill data.
    always_ff @(posedge clk or posedge clr_i) begin
        if (clr_i) begin
            line_q <= '0;
        end else if (ld_i) begin
            line_q <= ld_line_i;
        end else if (we_i) begin
            line_q[beat_i*WORD_W +: WORD_W] <= wdata_i;
        end
    end

    assign rdata_o = line_q[beat_i*WORD_W +: WORD_W];
    assign line_o  = line_q;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// rtl/dcache_miss_ctrl.sv - single-outstanding miss controller: victim flush then line refill
module dcache_miss_ctrl
    import dcache_msi_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               miss_valid_i,
    input  logic               miss_write_i,
    input  logic [31:0]        miss_addr_i,
    output logic               miss_ready_o,
    input  logic [1:0]         victim_state_i,
    input  logic [TAG_W-1:0]   victim_tag_i,
    input  logic [LINE_W-1:0]  victim_line_i,
    output logic               fill_valid_o,
    output logic [INDEX_W-1:0] fill_index_o,
    output logic [TAG_W-1:0]   fill_tag_o,
    output logic [1:0]         fill_state_o,
    output logic [LINE_W-1:0]  fill_line_o,
    output logic               bus_req_o,
    input  logic               bus_gnt_i,
    output logic [1:0]         bus_cmd_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [31:0]        mem_addr_o,
    output logic [WORD_W-1:0]  mem_wdata_o,
    input  logic               mem_ack_i,
    input  logic [WORD_W-1:0]  mem_rdata_i,
    output logic               busy_o
);

    miss_state_e        state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [1:0]         fill_state_q, fill_state_d;
    logic [TAG_W-1:0]   req_tag_q;
    logic [INDEX_W-1:0] req_index_q;
    logic               req_write_q;
    logic [1:0]         victim_state_q;
    logic [TAG_W-1:0]   victim_tag_q;
    logic               accept;
    logic               buf_we;
    logic [WORD_W-1:0]  buf_rdata;
    bus_cmd_e           bus_cmd;
    logic               unused_offset;

    assign unused_offset = ^miss_addr_i[OFFSET_W-1:0];

    line_beat_buffer u_line (
        .clk       (clk),
        .clr_i     (rst),
        .ld_i      (accept),
        .ld_line_i (victim_line_i),
        .we_i      (buf_we),
        .beat_i    (beat_q),
        .wdata_i   (mem_rdata_i),
        .rdata_o   (buf_rdata),
        .line_o    (fill_line_o)
    );

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        fill_state_d = fill_state_q;
        accept       = 1'b0;
        buf_we       = 1'b0;
        bus_req_o    = 1'b0;
        bus_cmd      = CMD_NONE;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        case (state_q)
            ST_IDLE: begin
                if (miss_valid_i) begin
                    accept  = 1'b1;
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                bus_req_o = 1'b1;
                if (bus_gnt_i) begin
                    state_d = (victim_state_q == MSI_M) ? ST_WB : ST_FILL;
                end
            end
            ST_WB: begin
                bus_req_o   = 1'b1;
                bus_cmd     = CMD_FLUSH;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {victim_tag_q, req_index_q, beat_q, 2'b00};
                mem_wdata_o = buf_rdata;
                if (mem_ack_i) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                bus_req_o  = 1'b1;
                bus_cmd    = req_write_q ? CMD_BUSRDX : CMD_BUSRD;
                mem_req_o  = 1'b1;
                mem_addr_o = {req_tag_q, req_index_q, beat_q, 2'b00};
                if (mem_ack_i) begin
                    buf_we = 1'b1;
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d      = ST_RESP;
                        fill_state_d = req_write_q ? MSI_M : MSI_S;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            beat_q         <= '0;
            fill_state_q   <= '0;
            req_tag_q      <= '0;
            req_index_q    <= '0;
            req_write_q    <= 1'b0;
            victim_state_q <= '0;
            victim_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            fill_state_q <= fill_state_d;
            if (accept) begin
                req_tag_q      <= miss_addr_i[31 -: TAG_W];
                req_index_q    <= miss_addr_i[OFFSET_W +: INDEX_W];
                req_write_q    <= miss_write_i;
                victim_state_q <= victim_state_i;
                victim_tag_q   <= victim_tag_i;
            end
        end
    end

    assign miss_ready_o = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign fill_valid_o = (state_q == ST_RESP);
    assign fill_tag_o   = req_tag_q;
    assign fill_index_o = req_index_q;
    assign fill_state_o = fill_state_q;
    assign bus_cmd_o    = bus_cmd;

endmodule
